// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry defaults, frame address type and per-pixel pipeline tag
package vga_pkg;
  localparam int DEF_VGA_WIDTH = 320;
  localparam int DEF_VGA_HEIGHT = 240;
  localparam int DEF_H_TOTAL = 400;
  localparam int DEF_V_TOTAL = 262;
  localparam int DEF_HS_START = 336;
  localparam int DEF_HS_END = 368;
  localparam int DEF_VS_START = 245;
  localparam int DEF_VS_END = 248;
  localparam int FRAME_PIXELS = DEF_VGA_WIDTH * DEF_VGA_HEIGHT;
  localparam int FRAME_ADDR_W = 17;
  typedef logic [FRAME_ADDR_W-1:0] frame_addr_t;
  typedef struct packed {
    logic vis;
    frame_addr_t addr;
    logic hsync;
    logic vsync;
    logic fs;
  } pix_tag_t;
  localparam pix_tag_t IDLE_TAG = '{vis: 1'b0, addr: '0, hsync: 1'b1, vsync: 1'b1, fs: 1'b0};
endpackage

// File: rtl/vga_pixel_streamer_if.sv
// vga_pixel_streamer_if: frame-buffer read port plus aligned pixel/sync outputs (master = streamer)
interface vga_pixel_streamer_if #(parameter int PIX_W = 8);
  import vga_pkg::*;
  frame_addr_t fb_rd_addr;
  logic [PIX_W-1:0] fb_rd_data;
  frame_addr_t frame_addr;
  logic vga_blank;
  logic thres;
  logic hsync;
  logic vsync;
  logic frame_start;
  modport master(output fb_rd_addr, frame_addr, vga_blank, thres, hsync, vsync, frame_start, input fb_rd_data);
  modport slave(input fb_rd_addr, frame_addr, vga_blank, thres, hsync, vsync, frame_start, output fb_rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters giving visible flag, raw active-low syncs, frame origin and frame end
module vga_timing_gen import vga_pkg::*; #(
  parameter int VGA_WIDTH = DEF_VGA_WIDTH,
  parameter int VGA_HEIGHT = DEF_VGA_HEIGHT,
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END = DEF_HS_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END = DEF_VS_END
) (
  input logic clk,
  input logic rst,
  output logic visible,
  output logic hsync,
  output logic vsync,
  output logic origin,
  output logic last
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_end;
  logic v_end;
  always_comb begin
    h_end = h == HW'(H_TOTAL - 1);
    v_end = v == VW'(V_TOTAL - 1);
    visible = (h < HW'(VGA_WIDTH)) && (v < VW'(VGA_HEIGHT));
    hsync = !((h >= HW'(HS_START)) && (h < HW'(HS_END)));
    vsync = !((v >= VW'(VS_START)) && (v < VW'(VS_END)));
    origin = (h == '0) && (v == '0);
    last = h_end && v_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_end ? '0 : h + 1'b1;
      v <= h_end ? (v_end ? '0 : v + 1'b1) : v;
    end
  end
endmodule

// File: rtl/vga_pixel_streamer.sv
// vga_pixel_streamer: raster frame-buffer reader with per-frame threshold and RAM_LAT+1 aligned pixel/sync outputs
module vga_pixel_streamer import vga_pkg::*; #(
  parameter int VGA_WIDTH = DEF_VGA_WIDTH,
  parameter int VGA_HEIGHT = DEF_VGA_HEIGHT,
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END = DEF_HS_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END = DEF_VS_END,
  parameter int PIX_W = 8,
  parameter int RAM_LAT = 2
) (
  input logic clk,
  input logic rst,
  input logic [PIX_W-1:0] thres_level,
  vga_pixel_streamer_if.master bus
);
  localparam frame_addr_t LAST = frame_addr_t'(VGA_WIDTH * VGA_HEIGHT - 1);
  logic visible;
  logic hs_raw;
  logic vs_raw;
  logic origin;
  logic last;
  frame_addr_t addr;
  logic [PIX_W-1:0] level_q;
  logic thres_q;
  pix_tag_t tag;
  pix_tag_t pipe [RAM_LAT+1];
  vga_timing_gen #(
    .VGA_WIDTH(VGA_WIDTH), .VGA_HEIGHT(VGA_HEIGHT), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .HS_START(HS_START), .HS_END(HS_END), .VS_START(VS_START), .VS_END(VS_END)
  ) timing (
    .clk(clk), .rst(rst), .visible(visible), .hsync(hs_raw), .vsync(vs_raw), .origin(origin), .last(last)
  );
  always_comb begin
    tag = '{vis: visible, addr: visible ? addr : '0, hsync: hs_raw, vsync: vs_raw, fs: origin};
    bus.fb_rd_addr = tag.addr;
    bus.frame_addr = pipe[RAM_LAT].addr;
    bus.vga_blank = !pipe[RAM_LAT].vis;
    bus.hsync = pipe[RAM_LAT].hsync;
    bus.vsync = pipe[RAM_LAT].vsync;
    bus.frame_start = pipe[RAM_LAT].fs;
    bus.thres = thres_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      level_q <= '1;
      thres_q <= 1'b0;
      for (int i = 0; i <= RAM_LAT; i++) pipe[i] <= IDLE_TAG;
    end else begin
      addr <= last ? '0 : (visible && addr != LAST) ? addr + 1'b1 : addr;
      if (origin) level_q <= thres_level;
      thres_q <= pipe[RAM_LAT-1].vis ? (bus.fb_rd_data >= level_q) : 1'b0;
      pipe[0] <= tag;
      for (int i = 1; i <= RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule

// File: tb/tb_vga_pixel_streamer.sv
// tb_vga_pixel_streamer: directed table and sequence checks on a reduced-geometry and a default-geometry streamer
module tb_vga_pixel_streamer;
  import vga_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] lvl = 8'd128;
  logic [7:0] lvl_d = 8'd128;
  logic mode = 1'b0;
  always #5 clk = ~clk;
  vga_pixel_streamer_if #(.PIX_W(8)) s_if ();
  vga_pixel_streamer_if #(.PIX_W(8)) d_if ();
  vga_pixel_streamer #(
    .VGA_WIDTH(8), .VGA_HEIGHT(4), .H_TOTAL(12), .V_TOTAL(7),
    .HS_START(9), .HS_END(11), .VS_START(5), .VS_END(6), .PIX_W(8), .RAM_LAT(2)
  ) dut_s (.clk(clk), .rst(rst), .thres_level(lvl), .bus(s_if));
  vga_pixel_streamer dut_d (.clk(clk), .rst(rst), .thres_level(lvl_d), .bus(d_if));
  frame_addr_t s_r1, s_r2, d_r1, d_r2;
  always @(posedge clk) begin
    s_r1 <= s_if.fb_rd_addr;
    s_r2 <= s_r1;
    d_r1 <= d_if.fb_rd_addr;
    d_r2 <= d_r1;
  end
  assign s_if.fb_rd_data = mode ? 8'd200 : {s_r2[3:0], 4'b0000};
  assign d_if.fb_rd_data = d_r2[7:0];
  int checks = 0;
  int fails = 0;
  int k = 0;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (k=%0d)", name, act, exp, k);
    end
  endtask
  typedef struct {
    int k;
    int fa;
    bit blank;
    bit th;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;
  vec_t tbl[15];
  int vis_n, th_n, th_err, seq_err, last_n, fs_n, nxt;
  int d_fs_k, d_hs_n, d_hs_first, d_vs_n, d_vis, d_th, d_err;
  bit ok;
  initial begin
    tbl[0] = '{1, 0, 1, 0, 1, 1, 0};
    tbl[1] = '{3, 0, 0, 0, 1, 1, 1};
    tbl[2] = '{10, 7, 0, 0, 1, 1, 0};
    tbl[3] = '{11, 0, 1, 0, 1, 1, 0};
    tbl[4] = '{12, 0, 1, 0, 0, 1, 0};
    tbl[5] = '{13, 0, 1, 0, 0, 1, 0};
    tbl[6] = '{14, 0, 1, 0, 1, 1, 0};
    tbl[7] = '{15, 8, 0, 1, 1, 1, 0};
    tbl[8] = '{22, 15, 0, 1, 1, 1, 0};
    tbl[9] = '{46, 31, 0, 1, 1, 1, 0};
    tbl[10] = '{51, 0, 1, 0, 1, 1, 0};
    tbl[11] = '{63, 0, 1, 0, 1, 0, 0};
    tbl[12] = '{75, 0, 1, 0, 1, 1, 0};
    tbl[13] = '{87, 0, 0, 0, 1, 1, 1};
    tbl[14] = '{104, 13, 0, 1, 1, 1, 0};
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.fa", int'(s_if.frame_addr), 0);
    chk("rst.blank", int'(s_if.vga_blank), 1);
    chk("rst.thres", int'(s_if.thres), 0);
    chk("rst.hsync", int'(s_if.hsync), 1);
    chk("rst.vsync", int'(s_if.vsync), 1);
    chk("rst.fs", int'(s_if.frame_start), 0);
    chk("rst.rdaddr", int'(s_if.fb_rd_addr), 0);
    chk("rst.d_blank", int'(d_if.vga_blank), 1);
    chk("rst.d_hsync", int'(d_if.hsync), 1);
    rst = 1'b0;
    nxt = 0;
    d_fs_k = -1;
    d_hs_first = -1;
    for (int n = 1; n <= 802; n++) begin
      step();
      foreach (tbl[i]) if (tbl[i].k == k) begin
        chk($sformatf("vec%0d.fa", i), int'(s_if.frame_addr), tbl[i].fa);
        chk($sformatf("vec%0d.blank", i), int'(s_if.vga_blank), int'(tbl[i].blank));
        chk($sformatf("vec%0d.thres", i), int'(s_if.thres), int'(tbl[i].th));
        chk($sformatf("vec%0d.hsync", i), int'(s_if.hsync), int'(tbl[i].hs));
        chk($sformatf("vec%0d.vsync", i), int'(s_if.vsync), int'(tbl[i].vs));
        chk($sformatf("vec%0d.fs", i), int'(s_if.frame_start), int'(tbl[i].fs));
      end
      if (k >= 3 && k <= 86) begin
        if (!s_if.vga_blank) begin
          vis_n++;
          th_n += int'(s_if.thres);
          if (int'(s_if.frame_addr) != nxt) seq_err++;
          if (s_if.thres != s_if.frame_addr[3]) th_err++;
          nxt++;
        end else if (s_if.thres) th_err++;
        if (s_if.frame_addr == 17'd31) last_n++;
        if (s_if.frame_start) fs_n++;
      end
      if (d_if.frame_start && d_fs_k < 0) d_fs_k = k;
      if (k >= 3 && k <= 402 && !d_if.hsync) begin
        d_hs_n++;
        if (d_hs_first < 0) d_hs_first = k;
      end
      if (!d_if.vsync) d_vs_n++;
      if (k >= 3 && !d_if.vga_blank) begin
        d_vis++;
        d_th += int'(d_if.thres);
        if (d_if.thres != d_if.frame_addr[7]) d_err++;
      end else if (d_if.thres) d_err++;
      if (k == 322) chk("d.fa319", int'(d_if.frame_addr), 319);
      if (k == 323) chk("d.blank320", int'(d_if.vga_blank), 1);
      if (k == 403) chk("d.fa320", int'(d_if.frame_addr), 320);
      if (k == 408) chk("d.fa325", int'(d_if.frame_addr), 325);
    end
    chk("s.frame_vis", vis_n, 32);
    chk("s.frame_seq_err", seq_err, 0);
    chk("s.frame_thres", th_n, 16);
    chk("s.frame_align_err", th_err, 0);
    chk("s.last_once", last_n, 1);
    chk("s.fs_once", fs_n, 1);
    chk("d.fs_k", d_fs_k, 3);
    chk("d.hs_low", d_hs_n, 32);
    chk("d.hs_first", d_hs_first, 339);
    chk("d.vs_low", d_vs_n, 0);
    chk("d.vis2lines", d_vis, 640);
    chk("d.thres2lines", d_th, 256);
    chk("d.align_err", d_err, 0);
    mode = 1'b1;
    lvl = 8'd0;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      ok = s_if.frame_start;
    end
    chk("wait_fs", int'(ok), 1);
    vis_n = 0;
    th_n = 0;
    for (int n = 0; n < 84; n++) begin
      if (n == 24) lvl = 8'd255;
      vis_n += int'(!s_if.vga_blank);
      th_n += int'(s_if.thres);
      step();
    end
    chk("lvl0.vis", vis_n, 32);
    chk("lvl0.thres", th_n, 32);
    chk("period.fs", int'(s_if.frame_start), 1);
    vis_n = 0;
    th_n = 0;
    for (int n = 0; n < 84; n++) begin
      vis_n += int'(!s_if.vga_blank);
      th_n += int'(s_if.thres);
      step();
    end
    chk("lvl255.vis", vis_n, 32);
    chk("lvl255.thres", th_n, 0);
    chk("period2.fs", int'(s_if.frame_start), 1);
    last_n = 0;
    for (int n = 0; n < 24; n++) begin
      if (s_if.frame_addr == 17'd31) last_n++;
      step();
    end
    rst = 1'b1;
    lvl = 8'd0;
    step();
    chk("midrst.fa", int'(s_if.frame_addr), 0);
    chk("midrst.blank", int'(s_if.vga_blank), 1);
    chk("midrst.hsync", int'(s_if.hsync), 1);
    chk("midrst.thres", int'(s_if.thres), 0);
    chk("midrst.no_last", last_n, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("restart.fs", int'(s_if.frame_start), 1);
    chk("restart.fa0", int'(s_if.frame_addr), 0);
    chk("restart.blank", int'(s_if.vga_blank), 0);
    chk("restart.thres", int'(s_if.thres), 1);
    step();
    chk("restart.fa1", int'(s_if.frame_addr), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_pixel_streamer.md
# vga_pixel_streamer

Raster source for the image-processing VGA path. It scans the 320x240 frame buffer in raster order and issues read addresses to the frame-buffer RAM. It thresholds each returned grayscale pixel against a per-frame level. It then drives `frame_addr`, `vga_blank` and `thres`, cycle-aligned with each other and with the sync outputs. These signals feed the centroid accumulator and the VGA output stage, so they must obey the accumulator's per-pixel, one-pixel-per-clock contract.

## Interface
- `VGA_WIDTH`, 320: visible pixels per line.
- `VGA_HEIGHT`, 240: visible lines per frame.
- `H_TOTAL`, 400: clocks per line, visible plus blanking.
- `V_TOTAL`, 262: lines per frame.
- `HS_START`, 336: first `h` with `hsync` asserted.
- `HS_END`, 368: first `h` with `hsync` deasserted.
- `VS_START`, 245: first `v` with `vsync` asserted.
- `VS_END`, 248: first `v` with `vsync` deasserted.
- `PIX_W`, 8: grayscale pixel width.
- `RAM_LAT`, 2: frame-buffer read latency in clocks, from address to data; allowed range 1..4.

Ports:
- `clk` in 1: single clock; one pixel per clock.
- `rst` in 1: synchronous, active-high reset.
- `thres_level` in PIX_W: threshold level; sampled once per frame.
- `fb_rd_addr` out 17: frame-buffer read address.
- `fb_rd_data` in PIX_W: read data; valid `RAM_LAT` clocks after the matching `fb_rd_addr`.
- `frame_addr` out 17: pixel index `v*VGA_WIDTH+h` of the current output pixel.
- `vga_blank` out 1: 1 outside the visible area.
- `thres` out 1: 1 when the visible pixel is >= the latched level.
- `hsync`, `vsync` out 1: active-low sync pulses.
- `frame_start` out 1: one-clock pulse with the first visible pixel at the output.

## Operation
- Stage 0 holds the counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1).
  - `h` wraps to 0 and increments `v`.
  - `v` wraps to 0 after V_TOTAL-1.
- Visible means `h<VGA_WIDTH` and `v<VGA_HEIGHT`.
- Stage-0 address is an incremental counter; no multiplier is used.
  - It increments on each visible clock.
  - It clears to 0 when the scan reaches (h=H_TOTAL-1, v=V_TOTAL-1).
  - It saturates at 76799 so it can never wrap.
- `fb_rd_addr` equals the stage-0 address on visible clocks and 0 when not visible.
- `thres_level` is captured into an internal register when stage 0 is at (h=0, v=0). Changes mid-frame take effect next frame.
- Compare stage, one clock after data arrival: `thres <= visible_d && (fb_rd_data >= level_q)`, unsigned compare.
- Delay line of RAM_LAT+1 stages carries visible, address, hsync, vsync and frame-start from stage 0 to the outputs.
- `frame_addr` output:
  - Equals the delayed address when visible.
  - Forced to 0 when blanked.
  - Consequence: 76799 appears on exactly one clock per frame, and the accumulator latches exactly once.
- `vga_blank` is the inverse of delayed visible.
- `thres` is 0 whenever `vga_blank`=1.
- Sync timing at stage 0:
  - `hsync`=0 for HS_START<=h<HS_END.
  - `vsync`=0 for VS_START<=v<VS_END.
  - Both are delayed identically to the other outputs.

## Timing
- Latency is RAM_LAT+1 clocks from stage-0 position to all outputs; every output has the same latency.
- Frame period is H_TOTAL*V_TOTAL clocks; each frame has VGA_WIDTH*VGA_HEIGHT clocks with `vga_blank`=0.
- Reset (synchronous):
  - Counters, address and delay line clear.
  - Outputs hold `vga_blank`=1, `thres`=0, `frame_addr`=0, `fb_rd_addr`=0, `hsync`=1, `vsync`=1, `frame_start`=0.
  - Level register resets to 2^PIX_W-1.
- After reset deassertion, stage 0 is at (0,0). The first `frame_start` appears RAM_LAT+1 clocks after the first non-reset clock.
- Reset mid-frame: outputs go to reset values on the next clock and the scan restarts at (0,0). No `frame_addr`=76799 is emitted for the aborted frame.
- `fb_rd_data` is ignored on non-visible slots, including X values.

## Structure
- Shared package `vga_pkg`:
  - VGA_WIDTH/VGA_HEIGHT defaults.
  - `FRAME_PIXELS` = 76800.
  - `FRAME_ADDR_W` = 17.
  - Sync timing defaults.
  - Typedef `frame_addr_t`.
- Sub-module `vga_timing_gen`: the h/v counters, visible flag and raw sync. The streamer adds the address counter, the level latch, the compare and the delay line.

## Test plan
- Check reset values: hold `rst` 5 clocks -> all outputs at the reset values listed in Timing; release -> `frame_start` pulses at clock RAM_LAT+1=3.
- Full frame with a constant RAM returning 200 and `thres_level`=128:
  - Expected: 76800 clocks with `thres`=1 and `vga_blank`=0.
  - Expected: `frame_addr` ascends 0..76799 with no gaps.
  - Expected: 76799 occurs exactly once; frame period is 104800 clocks.
- Alignment with a RAM model where `fb_rd_data`=addr[7:0] and level 128 -> `thres`=1 exactly where `frame_addr[7]`=1.
- Threshold change: switch level 0->255 at line 100 -> current frame stays all-1s; the next frame is all-0s.
- Reset mid-frame: assert `rst` at v=120, h=50 -> no `frame_addr`=76799 for that frame; the next frame starts cleanly at 0.
- Sync positions: `hsync` low 32 clocks per line starting 336 clocks after the line's first pixel; `vsync` low 3 lines starting at line 245; both offset by latency 3.
